// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: word/offset widths,
// the NOP encoding that fills empty IF/ID slots, and the fetch-state enum.
package if_stage_pkg;

    localparam int WORD_LEN      = 16;
    localparam int REG_FILE_SIZE = 24;
    localparam int PC_LEN        = 10;

    localparam logic [WORD_LEN-1:0] INSTR_NOP = 16'hF000;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HOLD,
        REDIR
    } fetch_state_e;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory read bus between the fetch stage (master) and a
// synchronous-read instruction memory (slave) with one cycle of latency.
interface if_stage_if
    import if_stage_pkg::*;
#(
    parameter int PC_W    = PC_LEN,
    parameter int INSTR_W = WORD_LEN
) ();

    logic               imem_rd_en;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_rd_en,
        output imem_addr,
        input  imem_rdata
    );

    modport slave (
        input  imem_rd_en,
        input  imem_addr,
        output imem_rdata
    );

endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: holds while frozen, flushes to a NOP bubble on a
// redirect, and otherwise loads either the skid entry or the returning read.
module if_stage_if_id_reg
    import if_stage_pkg::*;
#(
    parameter int PC_W    = PC_LEN,
    parameter int INSTR_W = WORD_LEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_hold,
    input  logic               i_flush,
    input  logic               i_load_skid,
    input  logic               i_load_mem,
    input  logic [INSTR_W-1:0] i_mem_instr,
    input  logic [PC_W-1:0]    i_mem_pc,
    input  logic [INSTR_W-1:0] i_skid_instr,
    input  logic [PC_W-1:0]    i_skid_pc,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_pc,
    output logic               o_valid
);

    // The skid entry is always older than the read returning alongside it,
    // so it wins the load select.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_instr <= INSTR_W'(INSTR_NOP);
            o_pc    <= '0;
        end else if (!i_hold) begin
            if (i_flush) begin
                o_valid <= 1'b0;
                o_instr <= INSTR_W'(INSTR_NOP);
            end else if (i_load_skid) begin
                o_valid <= 1'b1;
                o_instr <= i_skid_instr;
                o_pc    <= i_skid_pc;
            end else if (i_load_mem) begin
                o_valid <= 1'b1;
                o_instr <= i_mem_instr;
                o_pc    <= i_mem_pc;
            end else begin
                o_valid <= 1'b0;
                o_instr <= INSTR_W'(INSTR_NOP);
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues word reads to the instruction
// memory and feeds the IF/ID register, honouring freeze and taken branches.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int PC_W    = PC_LEN,
    parameter int INSTR_W = WORD_LEN,
    parameter int OFS_W   = REG_FILE_SIZE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               br_taken,
    input  logic [OFS_W-1:0]   br_offset,
    if_stage_if.master         imem,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc_out,
    output logic               valid_out
);

    generate
        if (INSTR_W != WORD_LEN) begin : g_bad_instr_w
            $error("if_stage: INSTR_W must equal WORD_LEN");
        end
        if (OFS_W != REG_FILE_SIZE) begin : g_bad_ofs_w
            $error("if_stage: OFS_W must equal REG_FILE_SIZE");
        end
    endgenerate

    fetch_state_e       r_state;
    fetch_state_e       w_next_state;
    logic [PC_W-1:0]    r_pc;
    logic               r_inflight_v;
    logic [PC_W-1:0]    r_inflight_pc;
    logic               r_skid_v;
    logic [INSTR_W-1:0] r_skid_instr;
    logic [PC_W-1:0]    r_skid_pc;

    logic               w_issue;
    logic               w_branch;
    logic               w_capture;
    logic               w_load_skid;
    logic               w_load_mem;
    logic [PC_W-1:0]    w_target;
    logic               w_unused_ofs;

    // Offset is applied modulo the PC width; the upper offset bits cannot
    // change a wrapped word address.
    assign w_target     = pc_out + br_offset[PC_W-1:0];
    assign w_unused_ofs = ^br_offset[OFS_W-1:PC_W];

    assign imem.imem_rd_en = w_issue;
    assign imem.imem_addr  = r_pc;

    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_branch     = 1'b0;
        w_capture    = 1'b0;
        w_load_skid  = 1'b0;
        w_load_mem   = 1'b0;
        if (!rst) begin
            w_issue     = !freeze;
            w_branch    = !freeze && br_taken && valid_out;
            w_capture   = freeze && r_inflight_v;
            w_load_skid = !freeze && r_skid_v;
            w_load_mem  = !freeze && !r_skid_v && r_inflight_v;
        end
        case (r_state)
            BOOT:    w_next_state = freeze ? HOLD : RUN;
            RUN:     w_next_state = freeze ? HOLD : (w_branch ? REDIR : RUN);
            HOLD:    w_next_state = freeze ? HOLD : (w_branch ? REDIR : RUN);
            REDIR:   w_next_state = freeze ? HOLD : RUN;
            default: w_next_state = RUN;
        endcase
    end

    // A read issued in the branch cycle is squashed by clearing inflight_v;
    // a read that lands while frozen parks in the one-entry skid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= BOOT;
            r_pc          <= '0;
            r_inflight_v  <= 1'b0;
            r_inflight_pc <= '0;
            r_skid_v      <= 1'b0;
            r_skid_instr  <= INSTR_W'(INSTR_NOP);
            r_skid_pc     <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_branch) begin
                r_pc         <= w_target;
                r_inflight_v <= 1'b0;
                r_skid_v     <= 1'b0;
            end else if (w_issue) begin
                r_pc          <= r_pc + PC_W'(1);
                r_inflight_v  <= 1'b1;
                r_inflight_pc <= r_pc;
                r_skid_v      <= 1'b0;
            end else if (w_capture) begin
                r_skid_v     <= 1'b1;
                r_skid_instr <= imem.imem_rdata;
                r_skid_pc    <= r_inflight_pc;
                r_inflight_v <= 1'b0;
            end
        end
    end

    if_stage_if_id_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_if_id_reg (
        .clk          (clk),
        .rst          (rst),
        .i_hold       (freeze),
        .i_flush      (w_branch),
        .i_load_skid  (w_load_skid),
        .i_load_mem   (w_load_mem),
        .i_mem_instr  (imem.imem_rdata),
        .i_mem_pc     (r_inflight_pc),
        .i_skid_instr (r_skid_instr),
        .i_skid_pc    (r_skid_pc),
        .o_instr      (instr_out),
        .o_pc         (pc_out),
        .o_valid      (valid_out)
    );

endmodule
